mips_mc_sequencer: RTL
======================

MIPS_MC_SEQUENCER -- requirements
Module: mips_mc_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum wait cycles for mem_ready before a bus-error trap; legal range 1..65535.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 opcode  in  6  instruction bits [31:26], valid from DECODE onward.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory completion; sampled only while mem_req=1.
REQ-007 mem_req  out  1  memory access request.
REQ-008 mem_we  out  1  write qualifier for mem_req.
REQ-009 i_or_d  out  1  address select: 0=PC, 1=ALUOut.
REQ-010 ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath controls.
REQ-011 alu_src_b, alu_op, pc_source  out  2 each  datapath selects; pc_source 00=PC+4, 01=branch target, 10=jump target, 11=exception vector.
REQ-012 pc_write_en  out  1  PC load enable.
REQ-013 instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-014 illegal_op, bus_err  out  1 each  one-cycle trap cause pulses.

Function
REQ-015 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP.
REQ-016 Outputs are Moore functions of state only, except pc_write_en = pc_write | (pc_write_cond & zero).
REQ-017 FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; on mem_ready=1, ir_write=1, pc_write=1, next state DECODE; otherwise hold.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000->I_EXEC, any other->TRAP with cause illegal.
REQ-019 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_RD for lw, MEM_WR for sw.
REQ-020 MEM_RD: mem_req=1, i_or_d=1, mem_we=0; on mem_ready -> MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
REQ-021 MEM_WR: mem_req=1, mem_we=1, i_or_d=1; on mem_ready, instr_done=1 -> FETCH.
REQ-022 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
REQ-023 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, instr_done=1 -> FETCH.
REQ-025 JUMP: pc_source=10, pc_write=1, instr_done=1 -> FETCH.
REQ-026 Wait counter clears on entry to any mem_req state and increments each cycle with mem_ready=0; at count = MEM_TIMEOUT with mem_ready still 0, next state is TRAP with cause bus error.
REQ-027 mem_ready=1 on the timeout cycle completes the access normally; no trap.
REQ-028 TRAP (one cycle): pc_source=11, pc_write=1, instr_done=1, exactly one of illegal_op/bus_err=1 per latched cause -> FETCH.
REQ-029 Cumulative instruction latency with mem_ready asserted immediately: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
REQ-030 All outputs not listed for a state are 0; mem_we is never 1 without mem_req.

Reset
REQ-031 rst_n=0 at a rising edge forces FETCH, clears wait counter and trap cause, and abandons any in-flight access.
REQ-032 During and on the first cycle after reset, outputs equal FETCH decode with mem_ready ignored while rst_n=0; instr_done, illegal_op, bus_err are 0.

Structure
REQ-033 State enum, opcode constants, pc_source/alu_op/alu_src_b encodings in shared package mips_pkg.
REQ-034 One sub-module mips_ctrl_decode: combinational state-to-control output decode; next-state logic and counter stay in the top module.

Verification
REQ-035 Reset, then lw (0x23) with mem_ready 1 cycle after each request -> states FETCH,FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_RD,MEM_WB; single reg_write with mem_to_reg=1.
REQ-036 beq (0x04) with zero=1 -> pc_write_en=1, pc_source=01 in BRANCH; with zero=0 -> pc_write_en=0; both take 3 cycles.
REQ-037 opcode 0x3F -> TRAP one cycle, illegal_op=1, pc_source=11, pc_write_en=1, then FETCH.
REQ-038 MEM_TIMEOUT=4, mem_ready held 0 in MEM_RD -> TRAP after 4 wait cycles with bus_err=1; repeat with mem_ready on the 4th cycle -> MEM_WB, no trap.
REQ-039 rst_n=0 for one cycle while in MEM_WR -> next state FETCH, mem_we=0, no instr_done.
REQ-040 Back-to-back sequence R, addi, sw, j -> instr_done pulses at cycles 4, 8, 12, 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer.
// Purely declarative: no logic, no latency, no flow control.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef enum logic {
        CAUSE_ILLEGAL = 1'b0,
        CAUSE_BUS     = 1'b1
    } cause_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;
    localparam logic [1:0] PCSRC_EXC = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       instr_done;
        logic       illegal_op;
        logic       bus_err;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control decode; zero latency, no flow control.
// Only FETCH and MEM_WR look at mem_ready, which the caller gates during reset.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    input  cause_t i_cause,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_SEQ;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_BROFF;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_req    = 1'b1;
                o_ctrl.mem_we     = 1'b1;
                o_ctrl.i_or_d     = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            S_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_I_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REG;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_source     = PCSRC_BR;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_source  = PCSRC_JMP;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_TRAP: begin
                o_ctrl.pc_source  = PCSRC_EXC;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.instr_done = 1'b1;
                o_ctrl.illegal_op = (i_cause == CAUSE_ILLEGAL);
                o_ctrl.bus_err    = (i_cause == CAUSE_BUS);
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_sequencer.sv
// Multicycle MIPS control FSM: one state per cycle, 3-5 cycles per instruction.
// Memory states stall on mem_ready and trap to the exception vector after MEM_TIMEOUT waits.
module mips_mc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_i_or_d,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic       o_pc_write_en,
    output logic       o_instr_done,
    output logic       o_illegal_op,
    output logic       o_bus_err
);

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_wait_cnt;
    cause_t      r_cause;

    state_t      w_next;
    cause_t      w_next_cause;
    logic        w_timeout;
    state_t      w_dec_state;
    logic        w_ready;
    ctrl_t       w_ctrl;

    // Waits are counted before this cycle, so the trap fires on the MEM_TIMEOUT-th idle cycle.
    assign w_timeout = (r_wait_cnt == WAIT_LAST) && !i_mem_ready;

    always_comb begin
        w_next       = r_state;
        w_next_cause = r_cause;
        case (r_state)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (i_mem_ready) begin
                    w_next = (r_state == S_FETCH)  ? S_DECODE :
                             (r_state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_next_cause = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:     w_next = S_R_EXEC;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_I_EXEC;
                    default: begin
                        w_next       = S_TRAP;
                        w_next_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: w_next = (i_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_R_EXEC:   w_next = S_R_WB;
            S_I_EXEC:   w_next = S_I_WB;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_cause    <= CAUSE_ILLEGAL;
        end else begin
            r_state <= w_next;
            r_cause <= w_next_cause;
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (is_mem_state(r_state) && !i_mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
        end
    end

    // Reset presents FETCH controls with mem_ready masked so nothing is committed.
    assign w_dec_state = i_rst_n ? r_state : S_FETCH;
    assign w_ready     = i_mem_ready & i_rst_n;

    mips_ctrl_decode u_decode (
        .i_state     (w_dec_state),
        .i_mem_ready (w_ready),
        .i_cause     (r_cause),
        .o_ctrl      (w_ctrl)
    );

    assign o_mem_req     = w_ctrl.mem_req;
    assign o_mem_we      = w_ctrl.mem_we;
    assign o_i_or_d      = w_ctrl.i_or_d;
    assign o_ir_write    = w_ctrl.ir_write;
    assign o_reg_write   = w_ctrl.reg_write;
    assign o_reg_dst     = w_ctrl.reg_dst;
    assign o_mem_to_reg  = w_ctrl.mem_to_reg;
    assign o_alu_src_a   = w_ctrl.alu_src_a;
    assign o_alu_src_b   = w_ctrl.alu_src_b;
    assign o_alu_op      = w_ctrl.alu_op;
    assign o_pc_source   = w_ctrl.pc_source;
    assign o_pc_write_en = w_ctrl.pc_write | (w_ctrl.pc_write_cond & i_zero);
    assign o_instr_done  = w_ctrl.instr_done;
    assign o_illegal_op  = w_ctrl.illegal_op;
    assign o_bus_err     = w_ctrl.bus_err;

endmodule
